gray_to_bin_seq: RTL and testbench
==================================

Name: gray_to_bin_seq

Overview:
- Sequenced Gray-to-binary converter. It accepts one W-bit Gray sample on a valid/ready input and resolves it serially, MSB first, through a single shared XOR stage: one bit per clock.
- Presents the binary result on a valid/ready output.
- Checks each accepted sample against the previously accepted one for a legal single-bit Gray step, and flags violations alongside the result.
- Sits between an encoder/sensor front end and downstream position logic.

Parameters:
- W, 4, width of Gray input and binary output (W >= 1)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  reset; asynchronous, active-low
- in_valid  input  1  g_in holds a sample
- in_ready  output  1  block can accept a sample
- g_in  input  W  Gray-coded sample
- out_valid  output  1  b_out/step_err hold a result
- out_ready  input  1  consumer accepts the result
- b_out  output  W  binary result
- step_err  output  1  the sample just converted was not exactly one bit away from the previous accepted sample; meaningful only while out_valid=1
- busy  output  1  high in CONV or DONE

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, b_out=0, step_err=0, busy=0, prev_valid=0, internal sample/prev/index registers=0.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, latch g_in into g_reg, set idx=W-1, and go to CONV.
  - g_in is ignored whenever in_ready=0.
- CONV:
  - in_ready=0, busy=1.
  - Each edge writes b_reg[idx] = g_reg[idx] XOR (idx==W-1 ? 0 : b_reg[idx+1]), then decrements idx.
  - The edge that writes idx=0 moves to DONE.
  - The same edge registers step_err = prev_valid AND (popcount(g_reg XOR prev_g) != 1), then loads prev_g=g_reg and prev_valid=1.
- DONE:
  - out_valid=1.
  - b_out and step_err are held stable until an edge with out_ready=1, which returns to IDLE and clears out_valid.
  - in_ready rises in the cycle after the output handshake; there is no overlap of input and output handshakes.
- Latency: with acceptance on edge E0, out_valid is high from edge E0+W. Throughput is at most one sample per W+2 cycles.
- W=1: a single CONV cycle; b_out=g_in.
- Step check:
  - An identical repeated sample (popcount 0) is an error.
  - Multi-bit changes are errors.
  - Wrap-around (e.g. 1000 -> 0000 for W=4) is legal.
  - The first sample after reset never flags an error.
- b_out retains its last value after the output handshake until the next conversion overwrites it bit by bit. Consumers use b_out only while out_valid=1.
- Reset mid-operation (any state): return to the reset values immediately. The in-flight sample is dropped and not reported. prev_valid=0, so the next sample is unchecked.
- The in_valid/in_ready handshake completes on an edge when both are high. The out_valid/out_ready handshake completes on an edge when both are high.

Decomposition:
- Package gray_pkg:
  - state encoding constants/typedef (IDLE, CONV, DONE)
  - default width constant GRAY_W=4
- Sub-module gray_step_chk (combinational): inputs cur and prev (W bits); output one_bit_step = popcount(cur XOR prev)==1. It is instantiated once and sampled on the final CONV edge.

Test Plan:
- Reset, then in_valid with g_in=0000 -> in_ready drops next cycle; out_valid exactly 4 edges after acceptance; b_out=0000; step_err=0.
- Stream the full 4-bit Gray sequence 0000,0001,0011,0010,...,1000, then 0000 again, with out_ready=1 -> b_out counts 0..15 then 0; step_err=0 throughout, including the wrap.
- Send 0011 then 0101 -> b_out=0010 with step_err=0, then b_out=0110 with step_err=1.
- Send 0110 twice -> both results give b_out=0100; the second has step_err=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid/g_in -> out_valid, b_out and step_err stay stable; in_ready=0; no sample accepted.
- Assert rst_n=0 for one cycle during CONV -> all outputs return to their reset values asynchronously; the next sample 1111 yields b_out=1010 with step_err=0.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared constants for the sequenced Gray-to-binary converter:
// default width and FSM state encoding.
package gray_pkg;

    localparam int GRAY_W = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CONV = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/gray_step_chk.sv
// Combinational legality check for a Gray step: exactly one bit differs
// between the current and previous samples.
module gray_step_chk #(
    parameter int W = 4
) (
    input  logic [W-1:0] cur,
    input  logic [W-1:0] prev,
    output logic         one_bit_step
);

    logic [W-1:0] diff;

    assign diff         = cur ^ prev;
    assign one_bit_step = ($countones(diff) == 1);

endmodule

// File: rtl/gray_to_bin_seq.sv
// Serial Gray-to-binary converter: resolves one bit per clock, MSB first,
// through a single XOR stage, and flags illegal Gray steps between samples.
module gray_to_bin_seq
    import gray_pkg::*;
#(
    parameter int W = GRAY_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] g_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] b_out,
    output logic         step_err,
    output logic         busy
);

    localparam int IW = (W > 1) ? $clog2(W) : 1;

    logic [1:0]    state;
    logic [W-1:0]  g_reg;
    logic [W-1:0]  prev_g;
    logic          prev_valid;
    logic [W-1:0]  b_reg;
    logic [IW-1:0] idx;
    logic          err_reg;
    logic          one_bit_step;

    // Bit above the current index; the zero pad supplies the MSB's XOR input.
    logic [W:0]    b_ext;
    logic [W:0]    b_above;
    logic [IW:0]   idx_p1;
    logic          next_bit;

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high; valid never depends combinationally on ready.
    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign busy      = (state != ST_IDLE);
    assign b_out     = b_reg;
    assign step_err  = err_reg;

    assign b_ext    = {1'b0, b_reg};
    assign idx_p1   = {1'b0, idx} + {{IW{1'b0}}, 1'b1};
    assign b_above  = b_ext >> idx_p1;
    assign next_bit = g_reg[idx] ^ b_above[0];

    gray_step_chk #(.W(W)) u_step_chk (
        .cur          (g_reg),
        .prev         (prev_g),
        .one_bit_step (one_bit_step)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            g_reg      <= '0;
            prev_g     <= '0;
            prev_valid <= 1'b0;
            b_reg      <= '0;
            idx        <= '0;
            err_reg    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        g_reg <= g_in;
                        idx   <= IW'(W - 1);
                        state <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    b_reg[idx] <= next_bit;
                    if (idx == '0) begin
                        // Step check is taken on the final bit so it lands with the result.
                        err_reg    <= prev_valid & ~one_bit_step;
                        prev_g     <= g_reg;
                        prev_valid <= 1'b1;
                        state      <= ST_DONE;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gray_to_bin_seq.sv
// Directed bench for gray_to_bin_seq: literal checks per scenario plus a
// per-cycle comparison against a behavioural model of the conversion.
module tb_gray_to_bin_seq;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] g_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] b_out;
    logic         step_err;
    logic         busy;

    int total;
    int bad;

    // Expected results: {binary, step_err}
    logic [W:0] exp_q[$];
    logic [W-1:0] model_prev;
    logic         model_prev_valid;

    gray_to_bin_seq #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .g_in      (g_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .b_out     (b_out),
        .step_err  (step_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Inverse of the Gray encoding, found by search over all codes.
    function automatic logic [W-1:0] model_bin(input logic [W-1:0] g);
        logic [W-1:0] n;
        model_bin = '0;
        for (int i = 0; i < (1 << W); i++) begin
            n = W'(i);
            if ((n ^ (n >> 1)) == g) model_bin = n;
        end
    endfunction

    function automatic int hamming(input logic [W-1:0] a, input logic [W-1:0] b);
        hamming = 0;
        for (int i = 0; i < W; i++) if (a[i] != b[i]) hamming++;
    endfunction

    always @(negedge rst_n) begin
        exp_q.delete();
        model_prev_valid = 1'b0;
    end

    // Model: record each accepted sample's expected result.
    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready) begin
            exp_q.push_back({model_bin(g_in),
                             model_prev_valid && (hamming(g_in, model_prev) != 1)});
            model_prev       = g_in;
            model_prev_valid = 1'b1;
        end
    end

    // Compare: every cycle the output is valid, it must match the head of the queue.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                chk("model_unexpected_output", 32'(out_valid), 32'd0);
            end else begin
                chk("model_b_out", 32'(b_out), 32'(exp_q[0][W:1]));
                chk("model_step_err", 32'(step_err), 32'(exp_q[0][0]));
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Caller is just after a rising edge. Returns just after the edge that
    // raised out_valid, or after the output handshake when out_ready=1.
    task automatic send(input logic [W-1:0] g, input logic [W-1:0] eb,
                        input logic eerr, input string tag);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk({tag, "_in_ready_wait"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        g_in     = g;
        @(posedge clk); #1;
        in_valid = 1'b0;
        g_in     = W'($urandom_range(0, 15));
        chk({tag, "_in_ready_drop"}, 32'(in_ready), 32'd0);
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1; n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'(W));
        chk({tag, "_b_out"}, 32'(b_out), 32'(eb));
        chk({tag, "_step_err"}, 32'(step_err), 32'(eerr));
        if (out_ready) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [W-1:0] gv;
        logic [W-1:0] bv;
        total            = 0;
        bad              = 0;
        model_prev       = '0;
        model_prev_valid = 1'b0;
        rst_n            = 1'b0;
        in_valid         = 1'b0;
        g_in             = '0;
        out_ready        = 1'b1;

        do_reset();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_b_out", 32'(b_out), 32'd0);
        chk("rst_step_err", 32'(step_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        send(4'b0000, 4'b0000, 1'b0, "first");

        // Full Gray cycle plus the wrap back to zero.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            bv = W'(i % 16);
            gv = bv ^ (bv >> 1);
            send(gv, bv, 1'b0, "stream");
        end

        do_reset();
        send(4'b0011, 4'b0010, 1'b0, "pair_a");
        send(4'b0101, 4'b0110, 1'b1, "pair_b");

        do_reset();
        send(4'b0110, 4'b0100, 1'b0, "repeat_a");
        send(4'b0110, 4'b0100, 1'b1, "repeat_b");

        // Backpressure in DONE with noise on the input side.
        out_ready = 1'b0;
        send(4'b0111, 4'b0101, 1'b0, "bp");
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            g_in     = W'($urandom_range(0, 15));
            @(posedge clk); #1;
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_b_out", 32'(b_out), 32'b0101);
            chk("bp_step_err", 32'(step_err), 32'd0);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_out_valid", 32'(out_valid), 32'd0);
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        chk("bp_retain_b_out", 32'(b_out), 32'b0101);

        // Asynchronous reset in the middle of a conversion.
        do_reset();
        send(4'b0110, 4'b0100, 1'b0, "pre_rst_a");
        send(4'b0110, 4'b0100, 1'b1, "pre_rst_b");
        in_valid = 1'b1;
        g_in     = 4'b1001;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("mid_busy", 32'(busy), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_in_ready", 32'(in_ready), 32'd1);
        chk("async_out_valid", 32'(out_valid), 32'd0);
        chk("async_b_out", 32'(b_out), 32'd0);
        chk("async_step_err", 32'(step_err), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(4'b1111, 4'b1010, 1'b0, "post_rst");

        repeat (3) @(posedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
